vme_cmd_ctrl: RTL and testbench

VME_CMD_CTRL -- requirements
Module: vme_cmd_ctrl

---
 rtl/vme_cmd_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vme_cmd_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_cmd_ctrl.sv
// VME slave command controller: strobe synchronisation, board/device decode and DTACK handshake.
// Define VME_CMD_TIMEOUT_EN to add the acknowledge-timeout counter and sticky TIMEOUT flag.
module vme_cmd_ctrl #(
  parameter int NDEV        = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYCLES   = 255
) (
  input  logic            FASTCLK,
  input  logic            RST,
  input  logic [5:0]      GA_B,
  input  logic [5:0]      AM,
  input  logic [23:1]     ADR,
  input  logic            AS_B,
  input  logic            DS0_B,
  input  logic            DS1_B,
  input  logic            LWORD_B,
  input  logic            WRITE_B,
  input  logic            IACK_B,
  input  logic            SYSFAIL_B,
  input  logic [NDEV-1:0] DEV_ACK,
  output logic [NDEV-1:0] DEVICE,
  output logic [9:0]      COMMAND,
  output logic            STROBE,
  output logic            STRBCE,
  output logic            DTACK_B,
  output logic            TOVME_B,
  output logic            BUSY,
  output logic            TIMEOUT
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_STRB  = 3'd2;
  localparam logic [2:0] S_WACK  = 3'd3;
  localparam logic [2:0] S_DTACK = 3'd4;
  localparam logic [2:0] S_REL   = 3'd5;

  logic [2:0]             r_state;
  logic [2:0]             w_state_next;
  logic [SYNC_STAGES-1:0] r_as_sync;
  logic [SYNC_STAGES-1:0] r_ds0_sync;
  logic [SYNC_STAGES-1:0] r_ds1_sync;
  logic [23:1]            r_adr;
  logic [5:0]             r_am;
  logic [5:0]             r_ga_b;
  logic                   r_write_b;
  logic                   r_lword_b;
  logic                   w_as;
  logic                   w_ds0;
  logic                   w_ds1;
  logic [4:0]             w_slot;
  logic                   w_ga_par_ok;
  logic                   w_board_sel;
  logic                   w_valid;
  logic                   w_ack;
  logic                   w_to_hit;
  logic [NDEV-1:0]        w_device;

  assign w_as  = ~r_as_sync[SYNC_STAGES-1];
  assign w_ds0 = ~r_ds0_sync[SYNC_STAGES-1];
  assign w_ds1 = ~r_ds1_sync[SYNC_STAGES-1];

  // GAP makes the six active-high GA bits even (slot 5 -> GA_B=111010 is a good address)
  assign w_slot      = ~r_ga_b[4:0];
  assign w_ga_par_ok = ~^(~r_ga_b);
  assign w_board_sel = (&r_ga_b)
                     | (w_ga_par_ok & (r_adr[23:19] == w_slot))
                     | (r_adr[23:19] == 5'd25) | (r_adr[23:19] == 5'd27);
  assign w_valid     = w_board_sel & r_lword_b & (&r_am[5:3]) & (r_am[1] ^ r_am[0])
                     & IACK_B & SYSFAIL_B;

  genvar gi;
  generate
    for (gi = 0; gi < NDEV; gi++) begin : g_dev
      assign w_device[gi] = (r_adr[18:12] == 7'(gi));
    end
  endgenerate

  // Unmapped codes have no device to answer, so they acknowledge immediately
  assign w_ack = (|(DEV_ACK & w_device)) | ~(|w_device);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_as) w_state_next = S_ADDR;
      S_ADDR: begin
        if (!w_as)                         w_state_next = S_IDLE;
        else if (w_ds0 && w_ds1 && w_valid) w_state_next = S_STRB;
      end
      S_STRB:  w_state_next = w_as ? S_WACK : S_IDLE;
      S_WACK: begin
        if (!w_as)         w_state_next = S_IDLE;
        else if (w_ack)    w_state_next = S_DTACK;
        else if (w_to_hit) w_state_next = S_REL;
      end
      S_DTACK: begin
        if (!w_as)               w_state_next = S_IDLE;
        else if (!w_ds0 || !w_ds1) w_state_next = S_REL;
      end
      S_REL:   if (!w_as) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_as_sync  <= '1;
      r_ds0_sync <= '1;
      r_ds1_sync <= '1;
      r_adr      <= '0;
      r_am       <= '0;
      r_ga_b     <= '0;
      r_write_b  <= 1'b0;
      r_lword_b  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_as_sync  <= {r_as_sync[SYNC_STAGES-2:0], AS_B};
      r_ds0_sync <= {r_ds0_sync[SYNC_STAGES-2:0], DS0_B};
      r_ds1_sync <= {r_ds1_sync[SYNC_STAGES-2:0], DS1_B};
      if (r_state == S_IDLE && w_as) begin
        r_adr     <= ADR;
        r_am      <= AM;
        r_ga_b    <= GA_B;
        r_write_b <= WRITE_B;
        r_lword_b <= LWORD_B;
      end
    end
  end

`ifdef VME_CMD_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_CYCLES + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to_hit = (r_to_cnt + TO_W'(1)) == TO_W'(TO_CYCLES);
  assign TIMEOUT  = r_timeout;

  always_ff @(posedge FASTCLK) begin
    if (RST) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_STRB)      r_to_cnt <= '0;
      else if (r_state == S_WACK) r_to_cnt <= r_to_cnt + TO_W'(1);
      if (r_state == S_ADDR && w_state_next == S_STRB)     r_timeout <= 1'b0;
      else if (r_state == S_WACK && w_state_next == S_REL) r_timeout <= 1'b1;
    end
  end
`else
  assign w_to_hit = 1'b0;
  assign TIMEOUT  = 1'b0;
`endif

  assign DEVICE  = (r_state == S_IDLE) ? '0 : w_device;
  assign COMMAND = r_adr[11:2];
  assign STROBE  = (r_state == S_STRB) | (r_state == S_WACK);
  assign STRBCE  = (r_state == S_STRB);
  assign DTACK_B = ~(r_state == S_DTACK);
  assign TOVME_B = ~(((r_state == S_STRB) | (r_state == S_WACK) | (r_state == S_DTACK)) & r_write_b);
  assign BUSY    = (r_state != S_IDLE);

endmodule

// File: tb/tb_vme_cmd_ctrl.sv
// Bench for vme_cmd_ctrl: phase-level reference model compared every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_vme_cmd_ctrl;
  localparam int NDEV = 10;
  localparam int SYNC = 2;
`ifdef VME_CMD_TIMEOUT_EN
  localparam int TO_CYC = 16;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TO_CYC = 255;
  localparam bit TO_EN  = 1'b0;
`endif
  localparam int P_IDLE = 0, P_ADDR = 1, P_STRB = 2, P_WACK = 3, P_DTACK = 4, P_REL = 5;

  logic clk = 1'b0;
  logic RST = 1'b1;
  logic [5:0] GA_B = 6'b111010, AM = 6'h39;
  logic [23:1] ADR = '0;
  logic AS_B = 1'b1, DS0_B = 1'b1, DS1_B = 1'b1;
  logic LWORD_B = 1'b1, WRITE_B = 1'b1, IACK_B = 1'b1, SYSFAIL_B = 1'b1;
  logic [NDEV-1:0] DEV_ACK = '0;
  logic [NDEV-1:0] DEVICE;
  logic [9:0] COMMAND;
  logic STROBE, STRBCE, DTACK_B, TOVME_B, BUSY, TIMEOUT;

  vme_cmd_ctrl #(.NDEV(NDEV), .SYNC_STAGES(SYNC), .TO_CYCLES(TO_CYC)) dut (
    .FASTCLK(clk), .RST(RST), .GA_B(GA_B), .AM(AM), .ADR(ADR),
    .AS_B(AS_B), .DS0_B(DS0_B), .DS1_B(DS1_B), .LWORD_B(LWORD_B), .WRITE_B(WRITE_B),
    .IACK_B(IACK_B), .SYSFAIL_B(SYSFAIL_B), .DEV_ACK(DEV_ACK),
    .DEVICE(DEVICE), .COMMAND(COMMAND), .STROBE(STROBE), .STRBCE(STRBCE),
    .DTACK_B(DTACK_B), .TOVME_B(TOVME_B), .BUSY(BUSY), .TIMEOUT(TIMEOUT)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Reference model state
  int m_phase = P_IDLE;
  int m_wack = 0;
  bit m_timeout = 1'b0;
  logic [3:0] as_h = '1, ds0_h = '1, ds1_h = '1;
  logic [23:1] cap_adr = '0;
  logic [5:0] cap_am = '0, cap_ga = '0;
  logic cap_wr = 1'b0, cap_lw = 1'b0;

  // Responder and monitor bookkeeping
  logic [NDEV-1:0] ack_mask = '0;
  int ack_delay = 0, ack_cnt = 0;
  int strbce_cnt = 0, strbce_cyc = 0, strobe_cnt = 0, dtack_cnt = 0, tovme_cnt = 0;
  logic [NDEV-1:0] dev_at_strbce = '0;
  logic [9:0] cmd_at_strbce = '0;
  logic to_at_strbce = 1'b0;
  int ds_cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NDEV-1:0] exp_dev();
    logic [NDEV-1:0] d = '0;
    int code = int'(cap_adr[18:12]);
    if (m_phase != P_IDLE && code < NDEV) d[code] = 1'b1;
    return d;
  endfunction

  function automatic bit cycle_ok();
    int slot = 31 - int'(cap_ga[4:0]);
    int hi = int'(cap_adr[23:19]);
    bit par_ok = ($countones(~cap_ga) % 2) == 0;
    bit sel = (cap_ga == 6'h3F) || (par_ok && hi == slot) || hi == 25 || hi == 27;
    return sel && cap_lw && (cap_am[5:3] == 3'b111) && (cap_am[1] != cap_am[0]) && IACK_B && SYSFAIL_B;
  endfunction

  // Reference model: advances once per rising edge from the pins as they stood at that edge
  initial forever begin : model
    bit as_s, ds0_s, ds1_s;
    @(posedge clk);
    cyc++;
    if (RST) begin
      m_phase = P_IDLE; m_timeout = 1'b0; m_wack = 0;
      as_h = '1; ds0_h = '1; ds1_h = '1;
      cap_adr = '0; cap_am = '0; cap_ga = '0; cap_wr = 1'b0; cap_lw = 1'b0;
    end else begin
      as_s = !as_h[SYNC-1]; ds0_s = !ds0_h[SYNC-1]; ds1_s = !ds1_h[SYNC-1];
      if (m_phase != P_IDLE && !as_s) m_phase = P_IDLE;
      else case (m_phase)
        P_IDLE: if (as_s) begin
          m_phase = P_ADDR;
          cap_adr = ADR; cap_am = AM; cap_ga = GA_B; cap_wr = WRITE_B; cap_lw = LWORD_B;
        end
        P_ADDR: if (ds0_s && ds1_s && cycle_ok()) begin m_phase = P_STRB; m_timeout = 1'b0; end
        P_STRB: begin m_phase = P_WACK; m_wack = 0; end
        P_WACK: begin
          m_wack++;
          if (exp_dev() == '0 || (DEV_ACK & exp_dev()) != '0) m_phase = P_DTACK;
          else if (TO_EN && m_wack == TO_CYC) begin m_phase = P_REL; m_timeout = 1'b1; end
        end
        P_DTACK: if (!ds0_s || !ds1_s) m_phase = P_REL;
        default: ;
      endcase
      as_h = {as_h[2:0], AS_B}; ds0_h = {ds0_h[2:0], DS0_B}; ds1_h = {ds1_h[2:0], DS1_B};
    end
  end

  // Compare process plus DUT-observing counters
  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("DEVICE", DEVICE, exp_dev());
      chk("COMMAND", COMMAND, cap_adr[11:2]);
      chk("STROBE", STROBE, m_phase == P_STRB || m_phase == P_WACK);
      chk("STRBCE", STRBCE, m_phase == P_STRB);
      chk("DTACK_B", DTACK_B, m_phase != P_DTACK);
      chk("TOVME_B", TOVME_B, !((m_phase == P_STRB || m_phase == P_WACK || m_phase == P_DTACK) && cap_wr));
      chk("BUSY", BUSY, m_phase != P_IDLE);
      chk("TIMEOUT", TIMEOUT, m_timeout);
    end
    if (STRBCE === 1'b1) begin
      strbce_cnt++; strbce_cyc = cyc;
      dev_at_strbce = DEVICE; cmd_at_strbce = COMMAND; to_at_strbce = TIMEOUT;
    end
    if (STROBE === 1'b1) strobe_cnt++;
    if (DTACK_B === 1'b0) dtack_cnt++;
    if (TOVME_B === 1'b0) tovme_cnt++;
  end

  // Device responder: raises the chosen acknowledge mask ack_delay cycles after STRB
  initial forever begin
    @(negedge clk);
    if (m_phase == P_STRB) ack_cnt = 0;
    else if (m_phase == P_WACK) ack_cnt++;
    DEV_ACK = (m_phase == P_WACK && ack_cnt >= ack_delay) ? ack_mask : '0;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic run_cycle(logic [5:0] ga, logic [23:1] adr, logic [5:0] am, logic wr_b, logic lw_b,
                           int ds_dly, int rel_gap, int max_wait, int abort_at);
    GA_B = ga; ADR = adr; AM = am; WRITE_B = wr_b; LWORD_B = lw_b;
    AS_B = 1'b0;
    if (ds_dly > 0) step(ds_dly);
    DS0_B = 1'b0; DS1_B = 1'b0; ds_cyc = cyc;
    for (int i = 0; i < max_wait; i++) begin
      if (m_phase == P_DTACK || m_phase == P_REL || abort_at == i) break;
      step(1);
    end
    DS0_B = 1'b1; DS1_B = 1'b1;
    if (rel_gap > 0) step(rel_gap);
    AS_B = 1'b1;
    for (int i = 0; i < 20 && m_phase != P_IDLE; i++) step(1);
    step(2);
  endtask

  initial begin
    int s0, d0, t0, b0, ok;
    logic [NDEV-1:0] m;
    step(3);
    chk("rst_DTACK_B", DTACK_B, 1); chk("rst_BUSY", BUSY, 0); chk("rst_DEVICE", DEVICE, 0);
    chk("rst_COMMAND", COMMAND, 0); chk("rst_TOVME_B", TOVME_B, 1); chk("rst_STROBE", STROBE, 0);
    chk("rst_TIMEOUT", TIMEOUT, 0);
    RST = 1'b0; chk_on = 1'b1;
    step(2);

    // Write to slot 5, device 3, acknowledged two cycles after STRBCE
    ack_mask = 10'h008; ack_delay = 2;
    s0 = strbce_cnt; d0 = dtack_cnt; t0 = tovme_cnt; b0 = strobe_cnt;
    run_cycle(6'b111010, {5'd5, 7'd3, 10'h2A5, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 40, -1);
    chk("wr_strbce_count", strbce_cnt - s0, 1);
    chk("wr_latency", strbce_cyc - ds_cyc, SYNC + 1);
    chk("wr_device", dev_at_strbce, 10'h008);
    chk("wr_command", cmd_at_strbce, 10'h2A5);
    chk("wr_strobe_cycles", strobe_cnt - b0, 3);
    chk("wr_dtack_cycles", dtack_cnt - d0, 3);
    chk("wr_tovme_low", tovme_cnt - t0, 0);

    // Same cycle as a read: bus driven in STRB, WACK and DTACK
    t0 = tovme_cnt;
    run_cycle(6'b111010, {5'd5, 7'd3, 10'h2A5, 1'b0}, 6'h39, 1'b1, 1'b1, 4, 2, 40, -1);
    chk("rd_tovme_cycles", tovme_cnt - t0, 6);

    // Wrong slot rejected, broadcast accepted
    s0 = strbce_cnt; d0 = dtack_cnt;
    run_cycle(6'b111010, {5'd6, 7'd3, 10'h001, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 12, -1);
    chk("badslot_strbce", strbce_cnt - s0, 0);
    chk("badslot_dtack", dtack_cnt - d0, 0);
    s0 = strbce_cnt; d0 = dtack_cnt;
    run_cycle(6'b111010, {5'd25, 7'd3, 10'h002, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 40, -1);
    chk("bcast_strbce", strbce_cnt - s0, 1);
    chk("bcast_dtack", dtack_cnt - d0, 3);

    // Unmapped device code: acknowledged after a single WACK cycle
    ack_mask = '0; b0 = strobe_cnt; d0 = dtack_cnt;
    run_cycle(6'b111010, {5'd5, 7'h20, 10'h003, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 40, -1);
    chk("unmapped_device", dev_at_strbce, 0);
    chk("unmapped_strobe_cycles", strobe_cnt - b0, 2);
    chk("unmapped_dtack", dtack_cnt - d0, 3);

`ifdef VME_CMD_TIMEOUT_EN
    // No acknowledge: released after 16 WACK cycles, TIMEOUT sticky until next STRBCE
    ack_mask = '0; b0 = strobe_cnt; d0 = dtack_cnt;
    run_cycle(6'b111010, {5'd5, 7'd3, 10'h004, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 40, -1);
    chk("to_strobe_cycles", strobe_cnt - b0, 17);
    chk("to_dtack", dtack_cnt - d0, 0);
    chk("to_flag_set", TIMEOUT, 1);
    ack_mask = 10'h008; ack_delay = 1;
    run_cycle(6'b111010, {5'd5, 7'd3, 10'h005, 1'b0}, 6'h39, 1'b0, 1'b1, 4, 2, 40, -1);
    chk("to_flag_clr_at_strbce", to_at_strbce, 0);
`endif

    // Reset while in DTACK
    ack_mask = 10'h008; ack_delay = 0;
    GA_B = 6'b111010; ADR = {5'd5, 7'd3, 10'h006, 1'b0}; AM = 6'h39; WRITE_B = 1'b0;
    AS_B = 1'b0; step(4); DS0_B = 1'b0; DS1_B = 1'b0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (DTACK_B == 1'b0) begin ok = 1; break; end
      step(1);
    end
    chk("rstdt_reach_dtack", ok, 1);
    RST = 1'b1; step(1);
    chk("rstdt_DTACK_B", DTACK_B, 1); chk("rstdt_BUSY", BUSY, 0);
    RST = 1'b0; AS_B = 1'b1; DS0_B = 1'b1; DS1_B = 1'b1;
    step(4);

    // AS released while waiting for an acknowledge
    ack_mask = '0;
    AS_B = 1'b0; step(4); DS0_B = 1'b0; DS1_B = 1'b0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (STROBE == 1'b1 && STRBCE == 1'b0) begin ok = 1; break; end
      step(1);
    end
    chk("abort_reach_wack", ok, 1);
    step(2); AS_B = 1'b1;
    step(SYNC); chk("abort_busy_before", BUSY, 1);
    step(1); chk("abort_busy_after", BUSY, 0); chk("abort_strobe", STROBE, 0);
    DS0_B = 1'b1; DS1_B = 1'b1; step(4);

    // Randomised cycles against the model
    for (int k = 0; k < 60; k++) begin
      logic [5:0] ga, am;
      logic [4:0] hi;
      logic [6:0] code;
      int sel;
      sel = $urandom_range(0, 3);
      ga = (sel == 1) ? 6'b111100 : (sel == 2) ? 6'b011010 : 6'b111010;
      sel = $urandom_range(0, 4);
      hi = (sel <= 1) ? ~ga[4:0] : (sel == 2) ? 5'd25 : (sel == 3) ? 5'd27 : 5'($urandom_range(0, 31));
      code = ($urandom_range(0, 5) == 0) ? 7'h20 : 7'($urandom_range(0, 11));
      sel = $urandom_range(0, 5);
      am = (sel == 0) ? 6'h39 : (sel == 1) ? 6'h3A : (sel == 2) ? 6'h3D :
           (sel == 3) ? 6'h3B : (sel == 4) ? 6'h29 : 6'h3E;
      m = '0;
      if (code < NDEV) m[code] = 1'b1;
      if ($urandom_range(0, 4) == 0) m = NDEV'($urandom_range(0, 1023));
      ack_mask = m; ack_delay = $urandom_range(0, 3);
      IACK_B = ($urandom_range(0, 9) != 0); SYSFAIL_B = ($urandom_range(0, 9) != 0);
      run_cycle(ga, {hi, code, 10'($urandom_range(0, 1023)), 1'b0}, am, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3), 40,
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
